noc_intr_injector: RTL and testbench



---
 rtl/noc_intr_injector.sv | 251 +++++++++++++++++++++++++
 tb/tb_noc_intr_injector.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_intr_injector.sv
// noc_intr_injector
//   Turns interrupt requests (linear tile id + 64-bit word) into 2-flit
//   MSG_TYPE_INTERRUPT packets on a valid/ready NoC channel. Requests are
//   buffered in a DEPTH-entry packet FIFO. The all-ones id broadcasts to
//   every tile. Out-of-range ids are accepted but dropped and counted.
//
//   Ports:
//     clk, rst          single clock, synchronous active-high reset
//     req_val/req_rdy   request handshake
//     req_tile_id       destination id (32'hFFFF_FFFF = broadcast)
//     req_data          interrupt word
//     noc_out_val/rdy   flit handshake towards the NoC
//     noc_out_data      flit (zero when noc_out_val is low)
//     drop_cnt          saturating count of dropped invalid-id requests
//     busy              FIFO non-empty or packet in flight

`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
`ifndef MSG_DST_X
`define MSG_DST_X 49:42
`endif
`ifndef MSG_DST_Y
`define MSG_DST_Y 41:34
`endif
`ifndef MSG_DST_FBITS
`define MSG_DST_FBITS 33:30
`endif
`ifndef MSG_LENGTH
`define MSG_LENGTH 29:22
`endif
`ifndef MSG_TYPE
`define MSG_TYPE 21:14
`endif
`ifndef NOC_FBITS_L1
`define NOC_FBITS_L1 4'b0000
`endif
`ifndef MSG_TYPE_INTERRUPT
`define MSG_TYPE_INTERRUPT 8'd32
`endif

module noc_intr_injector #(
    parameter int unsigned NUM_TILES = 9,
    parameter int unsigned GRID_X    = 3,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_val,
    output logic                       req_rdy,
    input  logic [31:0]                req_tile_id,
    input  logic [63:0]                req_data,
    output logic                       noc_out_val,
    input  logic                       noc_out_rdy,
    output logic [`NOC_DATA_WIDTH-1:0] noc_out_data,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic                       busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned REM_W = $clog2(NUM_TILES + 1);
    localparam int unsigned XY_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PLD
    } state_t;

    // Payload flit is formed at enqueue so the FIFO holds exactly what goes out.
    typedef struct packed {
        logic            bcast;
        logic [XY_W-1:0] x;
        logic [XY_W-1:0] y;
        logic [63:0]     pld;
    } entry_t;

    entry_t           fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;
    logic             full;
    logic             empty;
    entry_t           head;
    entry_t           new_entry;

    logic             id_bcast;
    logic             id_valid;
    logic             req_fire;
    logic             do_push;
    logic             do_pop;
    logic             last_pkt;

    state_t           state;
    state_t           state_nxt;
    logic [XY_W-1:0]  cur_x;
    logic [XY_W-1:0]  cur_y;
    logic [REM_W-1:0] remaining;
    logic [63:0]      hdr_flit;

    // Bits 15:9 of the interrupt word are not carried in the payload flit.
    logic             unused_data_bits;
    assign unused_data_bits = ^req_data[15:9];

    // ------------------------------------------------------------------
    // Request side / FIFO
    // ------------------------------------------------------------------
    assign full     = (count == OCC_W'(DEPTH));
    assign empty    = (count == '0);
    assign req_rdy  = !rst && !full;
    assign req_fire = req_val && req_rdy;
    assign id_bcast = (req_tile_id == '1);
    assign id_valid = (req_tile_id < 32'(NUM_TILES));
    assign do_push  = req_fire && (id_bcast || id_valid);
    assign head     = fifo_mem[rd_ptr];
    assign last_pkt = !head.bcast || (remaining == REM_W'(1));
    assign do_pop   = (state == ST_PLD) && noc_out_rdy && last_pkt;

    always_comb begin
        new_entry       = '0;
        new_entry.bcast = id_bcast;
        new_entry.pld   = {req_data[63:16], 7'b0, req_data[8:0]};
        if (!id_bcast) begin
            new_entry.x = XY_W'(req_tile_id % GRID_X);
            new_entry.y = XY_W'(req_tile_id / GRID_X);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            fifo_mem[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (req_fire && !id_bcast && !id_valid && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (!empty)      state_nxt = ST_HDR;
            ST_HDR:  if (noc_out_rdy) state_nxt = ST_PLD;
            ST_PLD:  if (noc_out_rdy) state_nxt = last_pkt ? ST_IDLE : ST_HDR;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    // Destination walk: unicast loads its own x/y with remaining=1, broadcast
    // sweeps the grid row by row from (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_x     <= '0;
            cur_y     <= '0;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        if (head.bcast) begin
                            cur_x     <= '0;
                            cur_y     <= '0;
                            remaining <= REM_W'(NUM_TILES);
                        end else begin
                            cur_x     <= head.x;
                            cur_y     <= head.y;
                            remaining <= REM_W'(1);
                        end
                    end
                end
                ST_PLD: begin
                    if (noc_out_rdy && !last_pkt) begin
                        if (cur_x == XY_W'(GRID_X - 1)) begin
                            cur_x <= '0;
                            cur_y <= cur_y + 1'b1;
                        end else begin
                            cur_x <= cur_x + 1'b1;
                        end
                        remaining <= remaining - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        hdr_flit                 = '0;
        hdr_flit[`MSG_DST_X]     = cur_x;
        hdr_flit[`MSG_DST_Y]     = cur_y;
        hdr_flit[`MSG_DST_FBITS] = `NOC_FBITS_L1;
        hdr_flit[`MSG_LENGTH]    = 8'd1;
        hdr_flit[`MSG_TYPE]      = `MSG_TYPE_INTERRUPT;
    end

    always_comb begin
        noc_out_val  = 1'b0;
        noc_out_data = '0;
        case (state)
            ST_HDR: begin
                noc_out_val  = 1'b1;
                noc_out_data = hdr_flit;
            end
            ST_PLD: begin
                noc_out_val  = 1'b1;
                noc_out_data = head.pld;
            end
            default: ;
        endcase
    end

    assign busy = !empty || (state != ST_IDLE);

endmodule

// File: tb/tb_noc_intr_injector.sv
module tb_noc_intr_injector;

    localparam int NT = 9;
    localparam int GX = 3;
    localparam int DP = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_val = 1'b0;
    logic          req_rdy;
    logic [31:0]   req_tile_id = '0;
    logic [63:0]   req_data = '0;
    logic          noc_out_val;
    logic          noc_out_rdy = 1'b0;
    logic [63:0]   noc_out_data;
    logic [CW-1:0] drop_cnt;
    logic          busy;

    always #5 clk = ~clk;

    noc_intr_injector #(
        .NUM_TILES(NT),
        .GRID_X(GX),
        .DEPTH(DP),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_val(req_val),
        .req_rdy(req_rdy),
        .req_tile_id(req_tile_id),
        .req_data(req_data),
        .noc_out_val(noc_out_val),
        .noc_out_rdy(noc_out_rdy),
        .noc_out_data(noc_out_data),
        .drop_cnt(drop_cnt),
        .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    // Model: queued requests, and the flit stream of the entry being sent.
    typedef struct {
        bit          bcast;
        int unsigned tid;
        logic [63:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] fq[$];
    int unsigned m_drop = 0;
    bit          synced = 0;
    int          dut_hs = 0;

    function automatic logic [63:0] hdr_flit(int unsigned x, int unsigned y);
        logic [63:0] f;
        f = '0;
        f[49:42] = x[7:0];
        f[41:34] = y[7:0];
        f[33:30] = 4'b0000;
        f[29:22] = 8'd1;
        f[21:14] = 8'd32;
        return f;
    endfunction

    function automatic logic [63:0] pld_flit(logic [63:0] d);
        return {d[63:16], 7'b0, d[8:0]};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expand(ent_t e);
        if (e.bcast) begin
            for (int t = 0; t < NT; t++) begin
                fq.push_back(hdr_flit(t % GX, t / GX));
                fq.push_back(pld_flit(e.data));
            end
        end else begin
            fq.push_back(hdr_flit(e.tid % GX, e.tid / GX));
            fq.push_back(pld_flit(e.data));
        end
    endtask

    // Drive one cycle of inputs, advance the model across the coming edge,
    // then compare every output at the following negedge.
    task automatic tick(bit v, logic [31:0] id, logic [63:0] d, bit r, bit rs);
        bit   can_acc;
        ent_t e;
        rst         = rs;
        req_val     = v;
        req_tile_id = id;
        req_data    = d;
        noc_out_rdy = r;
        if (noc_out_val && r && !rs) dut_hs++;
        if (rs) begin
            mq.delete();
            fq.delete();
            m_drop = 0;
            synced = 1;
        end else if (synced) begin
            can_acc = (mq.size() < DP);
            if (fq.size() != 0) begin
                if (r) begin
                    void'(fq.pop_front());
                    if (fq.size() == 0) void'(mq.pop_front());
                end
            end else if (mq.size() != 0) begin
                expand(mq[0]);
            end
            if (v && can_acc) begin
                if (id == 32'hFFFF_FFFF) begin
                    e.bcast = 1; e.tid = 0; e.data = d;
                    mq.push_back(e);
                end else if (id < NT) begin
                    e.bcast = 0; e.tid = id; e.data = d;
                    mq.push_back(e);
                end else if (m_drop < (1 << CW) - 1) begin
                    m_drop++;
                end
            end
        end
        @(negedge clk);
        if (synced) begin
            chk("req_rdy", 64'(req_rdy), 64'(!rst && (mq.size() < DP)));
            chk("val", 64'(noc_out_val), 64'(fq.size() != 0));
            chk("data", noc_out_data, (fq.size() != 0) ? fq[0] : 64'd0);
            chk("busy", 64'(busy), 64'(mq.size() != 0));
            chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        end
    endtask

    task automatic idle(bit r);
        tick(0, 32'd0, 64'd0, r, 0);
    endtask

    task automatic drain(string name, int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            idle(1);
            n++;
        end
        chk({name, "_drain_timeout"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int hs0;
        int n;
        bit v;
        bit r;
        bit rs;
        int sel;
        logic [31:0] id;
        logic [63:0] d;

        // Reset state
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        chk("rst_val", 64'(noc_out_val), 64'd0);
        chk("rst_data", noc_out_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_req_rdy", 64'(req_rdy), 64'd0);
        idle(0);
        chk("post_rst_req_rdy", 64'(req_rdy), 64'd1);

        // Unicast id 5
        tick(1, 32'd5, 64'h0123_4567_89AB_CDEF, 1, 0);
        chk("lat_idle_val", 64'(noc_out_val), 64'd0);
        chk("lat_idle_busy", 64'(busy), 64'd1);
        idle(1);
        chk("uni_hdr_val", 64'(noc_out_val), 64'd1);
        chk("uni_hdr", noc_out_data, 64'h0000_0804_0048_0000);
        idle(1);
        chk("uni_pld", noc_out_data, 64'h0123_4567_89AB_01EF);
        idle(1);
        chk("uni_done_busy", 64'(busy), 64'd0);
        chk("uni_done_val", 64'(noc_out_val), 64'd0);

        // Fill with downstream stalled
        for (int i = 0; i < DP; i++) begin
            tick(1, 32'(i), {$urandom, $urandom}, 0, 0);
        end
        chk("full_req_rdy", 64'(req_rdy), 64'd0);
        tick(1, 32'd1, 64'hDEAD, 0, 0);
        chk("full_hold_req_rdy", 64'(req_rdy), 64'd0);
        hs0 = dut_hs;
        drain("fill", 100);
        chk("fill_flits", 64'(dut_hs - hs0), 64'(2 * DP));

        // Broadcast
        hs0 = dut_hs;
        tick(1, 32'hFFFF_FFFF, 64'hA5A5_5A5A_F00D_BEEF, 1, 0);
        drain("bcast", 60);
        chk("bcast_flits", 64'(dut_hs - hs0), 64'd18);

        // Invalid ids, then id 0
        hs0 = dut_hs;
        tick(1, 32'd9, 64'h11, 1, 0);
        tick(1, 32'd9, 64'h22, 1, 0);
        tick(1, 32'd0, 64'h33, 1, 0);
        drain("inv", 20);
        chk("inv_drop", 64'(drop_cnt), 64'd2);
        chk("inv_flits", 64'(dut_hs - hs0), 64'd2);
        for (int i = 0; i < 8; i++) tick(1, 32'd100 + 32'(i), 64'h0, 1, 0);
        chk("drop_sat", 64'(drop_cnt), 64'd7);
        tick(1, 32'd12, 64'h0, 1, 0);
        idle(1);
        chk("drop_sat_hold", 64'(drop_cnt), 64'd7);

        // Reset while a header is presented
        tick(1, 32'd4, 64'h4444_4444_4444_4444, 0, 0);
        n = 0;
        while (!noc_out_val && n < 10) begin
            idle(0);
            n++;
        end
        chk("mid_hdr_reached", 64'(noc_out_val), 64'd1);
        tick(0, 0, 0, 1, 1);
        chk("mid_rst_val", 64'(noc_out_val), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
        idle(1);
        chk("mid_rst_no_stale", 64'(noc_out_val), 64'd0);
        tick(1, 32'd7, 64'hFEDC_BA98_7654_3210, 1, 0);
        idle(1);
        chk("fresh_hdr", noc_out_data, 64'h0000_0408_0048_0000);
        idle(1);
        chk("fresh_pld", noc_out_data, 64'hFEDC_BA98_7654_0010);
        drain("fresh", 10);

        // Random traffic with random backpressure and rare resets
        for (int c = 0; c < 3000; c++) begin
            v   = ($urandom_range(0, 2) != 0);
            sel = $urandom_range(0, 19);
            if (sel == 0) id = 32'hFFFF_FFFF;
            else if (sel < 3) id = 32'($urandom_range(9, 100));
            else id = 32'($urandom_range(0, NT - 1));
            d  = {$urandom, $urandom};
            r  = ($urandom_range(0, 1) != 0);
            rs = ($urandom_range(0, 499) == 0);
            tick(v, id, d, r, rs);
        end
        drain("rand", 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
